// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file and its clear sequencer.
package regfile_pkg;

    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefAddrWidth = 6;
    localparam int unsigned MaxSliceW    = 32;
    localparam int unsigned MaxVecW      = 128;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_e;

    // Extract slice `port` of `width` bits from a zero-extended packed vector.
    function automatic logic [MaxSliceW-1:0] port_slice(input logic [MaxVecW-1:0] vec,
                                                        input int unsigned port,
                                                        input int unsigned width);
        logic [MaxVecW-1:0] shifted;
        shifted = vec >> (port * width);
        return MaxSliceW'(shifted) & ((MaxSliceW'(1) << width) - MaxSliceW'(1));
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer: sweeps every address once after reset or on request, flagging busy meanwhile.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned AddrWidth = DefAddrWidth
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    output logic                 busy_o,
    output logic                 clear_write_o,
    output logic [AddrWidth-1:0] clear_addr_o
);

    clear_state_e         state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // A clear request during a running sweep is ignored.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (clear_i) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                end
            end
            CLEAR: begin
                addr_d = addr_q + AddrWidth'(1);
                if (&addr_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = CLEAR;
                addr_d  = '0;
            end
        endcase
    end

    assign busy_o        = (state_q == CLEAR);
    assign clear_write_o = (state_q == CLEAR);
    assign clear_addr_o  = addr_q;

endmodule

// File: rtl/param_register_file.sv
// Multi-port register file with optional write bypass, hardwired zero register and a clear sweep.
// Supports ReadPorts 1..4 and AddrWidth/DataWidth up to 32.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned AddrWidth = DefAddrWidth,
    parameter int unsigned ReadPorts = 2,
    parameter bit          Bypass    = 1'b0,
    parameter bit          ZeroReg   = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear_i,
    output logic                           busy_o,
    input  logic                           write_enable_i,
    input  logic [AddrWidth-1:0]           write_address_i,
    input  logic [DataWidth-1:0]           write_data_i,
    output logic                           write_dropped_o,
    input  logic [ReadPorts*AddrWidth-1:0] read_address_i,
    output logic [ReadPorts*DataWidth-1:0] read_data_o
);

    localparam int unsigned Depth = 2 ** AddrWidth;

    logic [DataWidth-1:0] mem_q [Depth];
    logic                 busy;
    logic                 clear_write;
    logic [AddrWidth-1:0] clear_addr;
    logic                 zero_wr;
    logic                 user_wr;
    logic                 write_dropped_q;

    regfile_clear_ctrl #(
        .AddrWidth (AddrWidth)
    ) u_clear_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (clear_i),
        .busy_o        (busy),
        .clear_write_o (clear_write),
        .clear_addr_o  (clear_addr)
    );

    assign zero_wr = ZeroReg && (write_address_i == '0);
    assign user_wr = write_enable_i && !busy && !zero_wr;

    // The array has no reset; the sweep is the only thing that zeroes it.
    always_ff @(posedge clk) begin
        if (clear_write) begin
            mem_q[clear_addr] <= '0;
        end else if (user_wr) begin
            mem_q[write_address_i] <= write_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_dropped_q <= 1'b0;
        end else begin
            write_dropped_q <= write_enable_i && busy && !zero_wr;
        end
    end

    for (genvar p = 0; p < ReadPorts; p++) begin : g_port
        logic [AddrWidth-1:0] raddr;
        logic [DataWidth-1:0] rdata;

        assign raddr = AddrWidth'(port_slice(MaxVecW'(read_address_i), p, AddrWidth));

        // Priority: busy forces zero, then zero register, then bypass over array.
        always_comb begin
            rdata = mem_q[raddr];
            if (Bypass && user_wr && (write_address_i == raddr)) begin
                rdata = write_data_i;
            end
            if (ZeroReg && (raddr == '0)) begin
                rdata = '0;
            end
            if (busy) begin
                rdata = '0;
            end
        end

        assign read_data_o[p*DataWidth +: DataWidth] = rdata;
    end

    assign busy_o          = busy;
    assign write_dropped_o = write_dropped_q;

endmodule
